// File: rtl/baby_store_render_pkg.sv
// Shared types and constants for the Baby store display renderer.
package baby_pkg;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } state_t;

  localparam int STORE_WORDS = 32;
  localparam int WORD_BITS   = 32;

  localparam logic [3:0] COL_OFF  = 4'h0;
  localparam logic [3:0] COL_DIM  = 4'h3;
  localparam logic [3:0] COL_FULL = 4'hF;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

endpackage

// File: rtl/baby_store_render_if.sv
// Video timing, store read port and colour output bundle for the renderer.
interface baby_store_render_if;

  logic [10:0] x;
  logic [10:0] y;
  logic        can_draw;
  logic        start_of_frame;
  logic        hsync_in;
  logic        vsync_in;
  logic [4:0]  action_line;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        hsync;
  logic        vsync;

  modport master (
    output x, y, can_draw, start_of_frame, hsync_in, vsync_in, action_line, mem_data,
    input  mem_addr, red, green, blue, hsync, vsync
  );

  modport slave (
    input  x, y, can_draw, start_of_frame, hsync_in, vsync_in, action_line, mem_data,
    output mem_addr, red, green, blue, hsync, vsync
  );

endinterface

// File: rtl/baby_store_render_cell_shader.sv
// Maps one store bit and its in-cell offset to a pixel colour (dot, gap or marker).
module baby_cell_shader
  import baby_pkg::*;
#(
  parameter int CELL_LOG2 = 4
) (
  input  logic                 i_bit,
  input  logic                 i_in_grid,
  input  logic                 i_marker,
  input  logic [CELL_LOG2-1:0] i_xo,
  input  logic [CELL_LOG2-1:0] i_yo,
  output rgb_t                 o_rgb
);

  localparam logic [CELL_LOG2-1:0] DOT_LO = CELL_LOG2'(2);
  localparam logic [CELL_LOG2-1:0] DOT_HI = CELL_LOG2'((1 << CELL_LOG2) - 3);

  logic w_x_dot;
  logic w_y_dot;

  assign w_x_dot = (i_xo >= DOT_LO) && (i_xo <= DOT_HI);
  assign w_y_dot = (i_yo >= DOT_LO) && (i_yo <= DOT_HI);

  always_comb begin
    o_rgb = '0;
    if (i_marker && w_y_dot) begin
      o_rgb.r = COL_FULL;
    end else if (i_in_grid && w_x_dot && w_y_dot) begin
      o_rgb.g = i_bit ? COL_FULL : COL_DIM;
    end
  end

endmodule

// File: rtl/baby_store_render.sv
// Three-stage pixel pipeline rendering the Baby store as a grid of bit-cells,
// with a red marker left of the row being executed.
module baby_store_render
  import baby_pkg::*;
#(
  parameter int ORIGIN_X  = 144,
  parameter int ORIGIN_Y  = 44,
  parameter int CELL_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  baby_store_render_if.slave bus
);

  localparam int CELL = 1 << CELL_LOG2;
  localparam int GW   = CELL_LOG2 + 5;

  localparam logic [10:0] X_LO = 11'(ORIGIN_X);
  localparam logic [10:0] X_HI = 11'(ORIGIN_X + WORD_BITS * CELL);
  localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + STORE_WORDS * CELL);
  localparam logic [10:0] M_LO = 11'(ORIGIN_X - 2 * CELL);
  localparam logic [10:0] M_HI = 11'(ORIGIN_X - CELL);

  state_t r_state;

  logic [GW-1:0]        w_gx;
  logic [GW-1:0]        w_gy;
  logic [4:0]           w_col;
  logic [4:0]           w_row;
  logic                 w_in_x;
  logic                 w_in_y;
  logic                 w_mark_x;

  logic [4:0]           r_s1_col;
  logic [CELL_LOG2-1:0] r_s1_xo;
  logic [CELL_LOG2-1:0] r_s1_yo;
  logic                 r_s1_grid;
  logic                 r_s1_mark;
  logic                 r_s1_run;
  logic                 r_s1_hs;
  logic                 r_s1_vs;
  logic [4:0]           r_mem_addr;

  logic                 r_s2_bit;
  logic [CELL_LOG2-1:0] r_s2_xo;
  logic [CELL_LOG2-1:0] r_s2_yo;
  logic                 r_s2_grid;
  logic                 r_s2_mark;
  logic                 r_s2_run;
  logic                 r_s2_hs;
  logic                 r_s2_vs;

  rgb_t                 w_rgb;
  rgb_t                 r_rgb;
  logic                 r_hs;
  logic                 r_vs;

  assign w_gx     = GW'(bus.x - X_LO);
  assign w_gy     = GW'(bus.y - Y_LO);
  assign w_col    = w_gx[CELL_LOG2 +: 5];
  assign w_row    = w_gy[CELL_LOG2 +: 5];
  assign w_in_x   = (bus.x >= X_LO) && (bus.x < X_HI);
  assign w_in_y   = (bus.y >= Y_LO) && (bus.y < Y_HI);
  assign w_mark_x = (bus.x >= M_LO) && (bus.x < M_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_SOF;
    end else if (r_state == WAIT_SOF && bus.start_of_frame) begin
      r_state <= RUN;
    end
  end

  // The run flag travels with each pixel, so rendering starts cleanly on the
  // pixel after start_of_frame rather than on whatever is already in flight.
  // The marker also requires y inside the grid so wrapped rows above/below it stay dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_col   <= '0;
      r_s1_xo    <= '0;
      r_s1_yo    <= '0;
      r_s1_grid  <= 1'b0;
      r_s1_mark  <= 1'b0;
      r_s1_run   <= 1'b0;
      r_s1_hs    <= 1'b0;
      r_s1_vs    <= 1'b0;
      r_mem_addr <= '0;
      r_s2_bit   <= 1'b0;
      r_s2_xo    <= '0;
      r_s2_yo    <= '0;
      r_s2_grid  <= 1'b0;
      r_s2_mark  <= 1'b0;
      r_s2_run   <= 1'b0;
      r_s2_hs    <= 1'b0;
      r_s2_vs    <= 1'b0;
      r_rgb      <= '0;
      r_hs       <= 1'b0;
      r_vs       <= 1'b0;
    end else begin
      r_s1_col   <= w_col;
      r_s1_xo    <= w_gx[CELL_LOG2-1:0];
      r_s1_yo    <= w_gy[CELL_LOG2-1:0];
      r_s1_grid  <= bus.can_draw && w_in_x && w_in_y;
      r_s1_mark  <= bus.can_draw && w_in_y && w_mark_x && (w_row == bus.action_line);
      r_s1_run   <= (r_state == RUN);
      r_s1_hs    <= bus.hsync_in;
      r_s1_vs    <= bus.vsync_in;
      r_mem_addr <= w_row;

      r_s2_bit   <= bus.mem_data[r_s1_col];
      r_s2_xo    <= r_s1_xo;
      r_s2_yo    <= r_s1_yo;
      r_s2_grid  <= r_s1_grid;
      r_s2_mark  <= r_s1_mark;
      r_s2_run   <= r_s1_run;
      r_s2_hs    <= r_s1_hs;
      r_s2_vs    <= r_s1_vs;

      r_rgb      <= r_s2_run ? w_rgb : '0;
      r_hs       <= r_s2_hs;
      r_vs       <= r_s2_vs;
    end
  end

  baby_cell_shader #(
    .CELL_LOG2(CELL_LOG2)
  ) u_shader (
    .i_bit    (r_s2_bit),
    .i_in_grid(r_s2_grid),
    .i_marker (r_s2_mark),
    .i_xo     (r_s2_xo),
    .i_yo     (r_s2_yo),
    .o_rgb    (w_rgb)
  );

  assign bus.mem_addr = r_mem_addr;
  assign bus.red      = r_rgb.r;
  assign bus.green    = r_rgb.g;
  assign bus.blue     = r_rgb.b;
  assign bus.hsync    = r_hs;
  assign bus.vsync    = r_vs;

endmodule

// File: tb/tb_baby_store_render.sv
// Directed bench for baby_store_render: each driven pixel carries a hand-computed
// colour expected exactly three clocks later.
module tb_baby_store_render;

  localparam logic [11:0] BLK = 12'h000;
  localparam logic [11:0] GRN = 12'h0F0;
  localparam logic [11:0] DIM = 12'h030;
  localparam logic [11:0] RED = 12'hF00;

  typedef struct packed {
    logic        v;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    int          id;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] mem [32];

  int n_cmp = 0;
  int n_err = 0;
  int n_bright = 0;
  int step_id = 0;
  string sect = "init";
  exp_t q[$];
  logic addr_v = 1'b0;
  logic [4:0] addr_exp = '0;

  baby_store_render_if bus ();

  baby_store_render #(
    .ORIGIN_X (144),
    .ORIGIN_Y (44),
    .CELL_LOG2(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Store modelled as a RAM whose address register is the DUT's mem_addr.
  assign bus.mem_data = mem[bus.mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic refill();
    exp_t e;
    e = '0;
    q.delete();
    repeat (3) q.push_back(e);
    addr_v = 1'b0;
  endtask

  task automatic drive(input logic [10:0] px, input logic [10:0] py, input logic cd,
                       input logic sof, input logic hs, input logic vs, input logic [11:0] e_rgb);
    exp_t e;
    logic [10:0] gy;
    @(negedge clk);
    e = q.pop_front();
    if (e.v) begin
      chk($sformatf("%s#%0d rgb", sect, e.id), {20'b0, bus.red, bus.green, bus.blue}, {20'b0, e.rgb});
      chk($sformatf("%s#%0d sync", sect, e.id), {30'b0, bus.hsync, bus.vsync}, {30'b0, e.hs, e.vs});
      if ({bus.red, bus.green, bus.blue} == GRN) n_bright++;
    end
    if (addr_v) chk($sformatf("%s#%0d addr", sect, step_id), {27'b0, bus.mem_addr}, {27'b0, addr_exp});
    bus.x = px;
    bus.y = py;
    bus.can_draw = cd;
    bus.start_of_frame = sof;
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    step_id++;
    e.v = 1'b1;
    e.rgb = e_rgb;
    e.hs = hs;
    e.vs = vs;
    e.id = step_id;
    q.push_back(e);
    gy = py - 11'd44;
    addr_exp = gy[8:4];
    addr_v = 1'b1;
  endtask

  task automatic flush();
    repeat (3) drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, BLK);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.x = 11'd200;
    bus.y = 11'd100;
    bus.can_draw = 1'b1;
    bus.start_of_frame = 1'b1;
    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b1;
    bus.action_line = 5'd3;
    for (int i = 0; i < 32; i++) mem[i] = 32'hFFFF_FFFF;
    refill();

    sect = "reset";
    repeat (3) @(negedge clk);
    chk("reset rgb", {20'b0, bus.red, bus.green, bus.blue}, 32'h0);
    chk("reset sync", {30'b0, bus.hsync, bus.vsync}, 32'h0);
    chk("reset addr", {27'b0, bus.mem_addr}, 32'h0);
    bus.start_of_frame = 1'b0;
    rst_n = 1'b1;

    sect = "nosof";
    drive(11'd200, 11'd100, 1'b1, 1'b0, 1'b1, 1'b0, BLK);
    drive(11'd200, 11'd100, 1'b1, 1'b0, 1'b0, 1'b1, BLK);
    drive(11'd200, 11'd100, 1'b1, 1'b0, 1'b0, 1'b0, BLK);
    drive(11'd146, 11'd46,  1'b1, 1'b0, 1'b1, 1'b1, BLK);
    drive(11'd162, 11'd46,  1'b1, 1'b0, 1'b0, 1'b0, BLK);
    flush();

    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[0] = 32'h0000_0001;
    sect = "render";
    drive(11'd0,   11'd0,  1'b0, 1'b1, 1'b1, 1'b1, BLK);
    drive(11'd146, 11'd46, 1'b1, 1'b0, 1'b0, 1'b0, GRN);
    drive(11'd162, 11'd46, 1'b1, 1'b0, 1'b1, 1'b0, DIM);
    drive(11'd144, 11'd46, 1'b1, 1'b0, 1'b0, 1'b0, BLK);
    drive(11'd143, 11'd46, 1'b1, 1'b0, 1'b0, 1'b0, BLK);
    drive(11'd146, 11'd46, 1'b0, 1'b0, 1'b0, 1'b0, BLK);
    drive(11'd146, 11'd45, 1'b1, 1'b0, 1'b0, 1'b0, BLK);
    drive(11'd146, 11'd57, 1'b1, 1'b0, 1'b0, 1'b0, GRN);
    drive(11'd157, 11'd46, 1'b1, 1'b0, 1'b0, 1'b0, GRN);
    drive(11'd158, 11'd46, 1'b1, 1'b0, 1'b0, 1'b0, BLK);
    drive(11'd146, 11'd62, 1'b1, 1'b0, 1'b0, 1'b0, DIM);
    drive(11'd146, 11'd46, 1'b1, 1'b1, 1'b0, 1'b1, GRN);
    drive(11'd162, 11'd46, 1'b1, 1'b0, 1'b0, 1'b0, DIM);
    flush();

    mem[31] = 32'hFFFF_FFFF;
    sect = "edge";
    drive(11'd655, 11'd555, 1'b1, 1'b0, 1'b0, 1'b0, BLK);
    drive(11'd656, 11'd550, 1'b1, 1'b0, 1'b0, 1'b0, BLK);
    drive(11'd653, 11'd550, 1'b1, 1'b0, 1'b0, 1'b0, GRN);
    drive(11'd653, 11'd556, 1'b1, 1'b0, 1'b0, 1'b0, BLK);
    drive(11'd653, 11'd555, 1'b1, 1'b0, 1'b0, 1'b0, BLK);
    drive(11'd10,  11'd92,  1'b0, 1'b0, 1'b0, 1'b0, BLK);
    drive(11'd10,  11'd20,  1'b0, 1'b0, 1'b0, 1'b0, BLK);
    drive(11'd146, 11'd46,  1'b1, 1'b0, 1'b0, 1'b0, GRN);

    sect = "marker";
    bus.action_line = 5'd5;
    drive(11'd120, 11'd128, 1'b1, 1'b0, 1'b0, 1'b0, RED);
    drive(11'd112, 11'd128, 1'b1, 1'b0, 1'b0, 1'b0, RED);
    drive(11'd111, 11'd128, 1'b1, 1'b0, 1'b0, 1'b0, BLK);
    drive(11'd127, 11'd128, 1'b1, 1'b0, 1'b0, 1'b0, RED);
    drive(11'd128, 11'd128, 1'b1, 1'b0, 1'b0, 1'b0, BLK);
    drive(11'd120, 11'd144, 1'b1, 1'b0, 1'b0, 1'b0, BLK);
    drive(11'd120, 11'd125, 1'b1, 1'b0, 1'b0, 1'b0, BLK);
    drive(11'd120, 11'd128, 1'b0, 1'b0, 1'b0, 1'b0, BLK);
    bus.action_line = 5'd6;
    drive(11'd120, 11'd144, 1'b1, 1'b0, 1'b0, 1'b0, RED);
    drive(11'd120, 11'd128, 1'b1, 1'b0, 1'b0, 1'b0, BLK);

    sect = "midrst";
    repeat (4) drive(11'd146, 11'd46, 1'b1, 1'b0, 1'b1, 1'b1, GRN);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst rgb", {20'b0, bus.red, bus.green, bus.blue}, 32'h0);
    chk("midrst sync", {30'b0, bus.hsync, bus.vsync}, 32'h0);
    chk("midrst addr", {27'b0, bus.mem_addr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    refill();
    sect = "postrst";
    repeat (4) drive(11'd146, 11'd46, 1'b1, 1'b0, 1'b1, 1'b0, BLK);
    drive(11'd0,   11'd0,  1'b0, 1'b1, 1'b0, 1'b0, BLK);
    drive(11'd146, 11'd46, 1'b1, 1'b0, 1'b0, 1'b1, GRN);
    drive(11'd162, 11'd46, 1'b1, 1'b0, 1'b0, 1'b0, DIM);
    flush();

    for (int i = 0; i < 32; i++) mem[i] = 32'h1 << i;
    bus.action_line = 5'd0;
    sect = "frame";
    n_bright = 0;
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        drive(11'(144 + c * 16 + 8), 11'(44 + r * 16 + 8), 1'b1, 1'b0, 1'b0, 1'b0,
              (c == r) ? GRN : DIM);
      end
      drive(11'd700, 11'(44 + r * 16 + 8), 1'b0, 1'b0, 1'b1, 1'b0, BLK);
    end
    flush();
    chk("frame bright count", 32'(n_bright), 32'd32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
